// File: rtl/bp_btb_pkg.sv
// Shared types and constants for the LC-3b branch target buffer.
package bp_btb_pkg;

   typedef logic [15:0] lc3b_word;

   localparam int unsigned IDX_W   = 4;
   localparam int unsigned ENTRIES = 1 << IDX_W;
   localparam int unsigned TAG_W   = 15 - IDX_W;

   // 2-bit saturating counter encodings
   localparam logic [1:0] SNT = 2'b00;
   localparam logic [1:0] WNT = 2'b01;
   localparam logic [1:0] WT  = 2'b10;
   localparam logic [1:0] ST  = 2'b11;

   localparam logic [1:0] CTR_INIT_DEF = WT;

   typedef struct packed {
      logic             valid;
      logic [TAG_W-1:0] tag;
      lc3b_word         target;
      logic [1:0]       ctr;
   } btb_entry_t;

   // PC bit 0 is ignored: instructions are word-aligned
   function automatic logic [IDX_W-1:0] pc_idx(input lc3b_word pc);
      return pc[IDX_W:1];
   endfunction

   function automatic logic [TAG_W-1:0] pc_tag(input lc3b_word pc);
      return pc[15:IDX_W+1];
   endfunction

endpackage

// File: rtl/sat_ctr2.sv
// 2-bit saturating up/down counter next-value function.
module sat_ctr2
   import bp_btb_pkg::*;
(
   input  logic [1:0] ctr,
   input  logic       up,
   output logic [1:0] ctr_next
);

   // Step toward ST on up, toward SNT otherwise, holding at the rails
   always_comb begin
      ctr_next = ctr;
      if (up) begin
         if (ctr != ST) ctr_next = ctr + 2'd1;
      end else begin
         if (ctr != SNT) ctr_next = ctr - 2'd1;
      end
   end

endmodule

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer with 2-bit counters and resolve statistics.
module bp_btb
   import bp_btb_pkg::*;
#(
   parameter logic [1:0] CTR_INIT = CTR_INIT_DEF
) (
   input  logic        clk,
   input  logic        rst,
   // fetch-side lookup
   input  logic [15:0] if_pc,
   output logic        if_pred_taken,
   output logic [15:0] if_pred_target,
   output logic        if_hit,
   // resolve-side update
   input  logic        upd_valid,
   input  logic [15:0] upd_pc,
   input  logic        upd_taken,
   input  logic [15:0] upd_target,
   input  logic        upd_uncond,
   input  logic        upd_pred_taken,
   input  logic [15:0] upd_pred_target,
   output logic        mispredict,
   // statistics
   input  logic        stat_clr,
   output logic [15:0] br_count,
   output logic [15:0] miss_count
);

   localparam btb_entry_t RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_INIT};

   btb_entry_t table_q [ENTRIES];
   logic       mispredict_q;
   logic [15:0] br_count_q, miss_count_q;

   btb_entry_t       if_entry;
   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   btb_entry_t       upd_entry;
   logic             upd_hit;
   logic [1:0]       ctr_sat;
   btb_entry_t       new_entry;
   logic             upd_write;
   logic             misp_cond;

   // Combinational lookup straight from table state, no bypass of a same-cycle update
   always_comb begin
      if_entry       = table_q[pc_idx(if_pc)];
      if_hit         = if_entry.valid && (if_entry.tag == pc_tag(if_pc));
      if_pred_taken  = if_hit && if_entry.ctr[1];
      if_pred_target = if_hit ? if_entry.target : 16'h0000;
   end

   assign upd_idx   = pc_idx(upd_pc);
   assign upd_tag   = pc_tag(upd_pc);
   assign upd_entry = table_q[upd_idx];
   assign upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

   sat_ctr2 u_sat_ctr2 (
      .ctr      (upd_entry.ctr),
      .up       (upd_taken),
      .ctr_next (ctr_sat)
   );

   // Next entry for the resolved branch: train on hit, allocate on taken miss
   always_comb begin
      upd_write = 1'b0;
      new_entry = upd_entry;
      if (upd_hit) begin
         upd_write     = 1'b1;
         new_entry.ctr = upd_uncond ? ST : ctr_sat;
         // indirect jumps may move their target, so refresh it on every taken hit
         if (upd_taken) new_entry.target = upd_target;
      end else if (upd_taken) begin
         upd_write        = 1'b1;
         new_entry.valid  = 1'b1;
         new_entry.tag    = upd_tag;
         new_entry.target = upd_target;
         new_entry.ctr    = upd_uncond ? ST : CTR_INIT;
      end
   end

   // Wrong direction, or right direction (taken) with the wrong target
   always_comb begin
      misp_cond = (upd_taken != upd_pred_taken) ||
                  (upd_taken && upd_pred_taken && (upd_target != upd_pred_target));
   end

   // Table storage; reset wins over a coincident update
   always_ff @(posedge clk) begin
      if (rst) begin
         table_q <= '{default: RESET_ENTRY};
      end else if (upd_valid && upd_write) begin
         table_q[upd_idx] <= new_entry;
      end
   end

   // One-cycle mispredict pulse following the resolve
   always_ff @(posedge clk) begin
      if (rst) begin
         mispredict_q <= 1'b0;
      end else begin
         mispredict_q <= upd_valid && misp_cond;
      end
   end

   // Saturating performance counters; clear beats increment
   always_ff @(posedge clk) begin
      if (rst || stat_clr) begin
         br_count_q   <= 16'h0000;
         miss_count_q <= 16'h0000;
      end else if (upd_valid) begin
         if (br_count_q != 16'hFFFF) br_count_q <= br_count_q + 16'd1;
         if (misp_cond && (miss_count_q != 16'hFFFF)) miss_count_q <= miss_count_q + 16'd1;
      end
   end

   assign mispredict = mispredict_q;
   assign br_count   = br_count_q;
   assign miss_count = miss_count_q;

endmodule
